// File: rtl/dwt_pkg.sv
// Shared types for the line DWT: mode encodings, lifting FSM states, coefficient width.
package dwt_pkg;

   localparam logic MODE_LEGALL53 = 1'b0;
   localparam logic MODE_HAAR     = 1'b1;

   typedef enum logic {
      S_EVEN = 1'b0,
      S_ODD  = 1'b1
   } state_t;

   function automatic int coef_w(input int data_w);
      return data_w + 1;
   endfunction

endpackage

// File: rtl/dwt_lift_step.sv
// Combinational predict/update step producing one (s, d) pair; no state, zero latency.
// Intermediates carry DATA_W+3 bits so 5/3 sums of two full-range details stay exact.
module dwt_lift_step
   import dwt_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                              haar,
   input  logic                              first,
   input  logic signed [DATA_W-1:0]          xe,
   input  logic signed [DATA_W-1:0]          xo,
   input  logic signed [DATA_W-1:0]          xn,
   input  logic signed [coef_w(DATA_W)-1:0]  dp,
   output logic signed [coef_w(DATA_W)-1:0]  s_o,
   output logic signed [coef_w(DATA_W)-1:0]  d_o
);

   localparam int CW = coef_w(DATA_W);
   localparam int IW = DATA_W + 3;
   localparam logic signed [IW-1:0] TWO = IW'(2);

   logic signed [IW-1:0] xe_w, xo_w, xn_w, d_w, dp_w, upd_w;

   always_comb begin
      xe_w = {{3{xe[DATA_W-1]}}, xe};
      xo_w = {{3{xo[DATA_W-1]}}, xo};
      xn_w = {{3{xn[DATA_W-1]}}, xn};
      if (haar)
         d_w = xo_w - xe_w;
      else
         d_w = xo_w - ((xe_w + xn_w) >>> 1);
      // the left edge mirrors d[0] in place of the missing d[-1]
      dp_w  = first ? d_w : {{2{dp[CW-1]}}, dp};
      upd_w = haar ? (d_w >>> 1) : ((dp_w + d_w + TWO) >>> 2);
      d_o   = CW'(d_w);
      s_o   = CW'(xe_w + upd_w);
   end

endmodule

// File: rtl/dwt_lift53_line.sv
// Line DWT, LeGall 5/3 (Haar selectable by mode when built with DWT_HAAR_EN); pair out 1 cycle after trigger.
// A held, unaccepted pair drops in_ready so no trigger sample is ever lost.
module dwt_lift53_line
   import dwt_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int LINE_LEN = 32
) (
   input  logic                              sys_clk,
   input  logic                              sys_rst,
   input  logic                              dwt_clr,
   input  logic                              mode,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic signed [DATA_W-1:0]          in_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic signed [coef_w(DATA_W)-1:0]  low_o,
   output logic signed [coef_w(DATA_W)-1:0]  high_o,
   output logic                              out_last,
   output logic                              line_done
);

   localparam int CW    = coef_w(DATA_W);
   localparam int CNT_W = $clog2(LINE_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_LEN - 1);

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic signed [DATA_W-1:0] x_even, x_odd;
   logic signed [CW-1:0]    d_prev, s_val, d_val;
   logic signed [DATA_W-1:0] xo_sel, xn_sel;
   logic                    accept, fin, trig, first_pair, line_haar;

`ifdef DWT_HAAR_EN
   logic mode_r;

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst)
         mode_r <= MODE_LEGALL53;
      else if (!dwt_clr && accept && cnt == '0)
         mode_r <= mode;
   end

   assign line_haar = (mode_r == MODE_HAAR);
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign line_haar   = 1'b0;
`endif

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      fin        = (cnt == CNT_LAST);
      first_pair = (cnt == CNT_W'(2));
      if (line_haar)
         trig = (state == S_ODD);
      else
         trig = (state == S_EVEN && cnt != '0) || fin;
      // the final 5/3 pair reflects x[LINE_LEN-2] as its right neighbour
      xo_sel = (line_haar || fin) ? in_data : x_odd;
      xn_sel = fin ? x_even : in_data;
   end

   dwt_lift_step #(.DATA_W(DATA_W)) u_step (
      .haar  (line_haar),
      .first (first_pair),
      .xe    (x_even),
      .xo    (xo_sel),
      .xn    (xn_sel),
      .dp    (d_prev),
      .s_o   (s_val),
      .d_o   (d_val)
   );

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state     <= S_EVEN;
         cnt       <= '0;
         x_even    <= '0;
         x_odd     <= '0;
         d_prev    <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         low_o     <= '0;
         high_o    <= '0;
         line_done <= 1'b0;
      end else begin
         line_done <= out_valid && out_ready && out_last;
         if (dwt_clr) begin
            state     <= S_EVEN;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end else begin
            if (out_ready)
               out_valid <= 1'b0;
            if (accept) begin
               cnt   <= fin ? '0 : cnt + 1'b1;
               state <= (state == S_EVEN) ? S_ODD : S_EVEN;
               if (state == S_EVEN)
                  x_even <= in_data;
               else
                  x_odd <= in_data;
               if (trig) begin
                  out_valid <= 1'b1;
                  low_o     <= s_val;
                  high_o    <= d_val;
                  out_last  <= fin;
                  d_prev    <= d_val;
               end
            end
         end
      end
   end

endmodule

// File: doc/dwt_lift53_line.md
DWT_LIFT53_LINE -- requirements
Module: dwt_lift53_line

Interface
REQ-001 Parameter DATA_W, default 8: signed input sample width, 4..16.
REQ-002 Parameter LINE_LEN, default 32: samples per line; even, 4..2048.
REQ-003 sys_clk  input  1  sole clock; all state on the rising edge.
REQ-004 sys_rst  input  1  asynchronous, active-low reset.
REQ-005 dwt_clr  input  1  synchronous line abort; active high.
REQ-006 mode  input  1  0 = LeGall 5/3 lifting, 1 = Haar; sampled only at line start.
REQ-007 in_valid / in_ready  input / output  1 / 1  sample handshake; a transfer occurs when both are high.
REQ-008 in_data  input  DATA_W  signed sample x[i].
REQ-009 out_valid / out_ready  output / input  1 / 1  coefficient-pair handshake.
REQ-010 low_o, high_o  output  DATA_W+1 each  signed s[n], d[n].
REQ-011 out_last  output  1  high with the final pair of a line.
REQ-012 line_done  output  1  one-cycle pulse, the cycle after the final pair transfers.

Function
REQ-013 The block shall run states S_EVEN (expecting x[2k]) and S_ODD (expecting x[2k+1]), with a sample counter cnt running 0..LINE_LEN-1.
- cnt wraps to 0 after the last sample.
- The state returns to S_EVEN at the wrap.
REQ-014 5/3 predict: d[n] = x[2n+1] - floor((x[2n]+x[2n+2])/2).
REQ-015 5/3 update: s[n] = x[2n] + floor((d[n-1]+d[n]+2)/4).
REQ-016 Boundaries: symmetric extension, x[LINE_LEN] = x[LINE_LEN-2] and d[-1] = d[0].
REQ-017 Haar: d[n] = x[2n+1] - x[2n], and s[n] = x[2n] + floor(d[n]/2).
REQ-018 Arithmetic shall be signed with arithmetic right shifts and no saturation; intermediates shall be wide enough that results in DATA_W+1 bits are exact.
REQ-019 Trigger sample for each pair:
- 5/3: pair n-1 is computed on acceptance of x[2n] for n >= 1; the final pair on acceptance of x[LINE_LEN-1].
- Haar: pair n is computed on acceptance of x[2n+1].
REQ-020 Output registers shall load the cycle after the trigger sample is accepted, giving latency 1.
REQ-021 Exactly LINE_LEN/2 pairs shall be emitted per line, in order n = 0, 1, ...
REQ-022 While out_valid=1 and out_ready=0, low_o, high_o and out_last shall hold stable.
REQ-023 in_ready = !out_valid || out_ready, so a trigger sample is never lost.
REQ-024 Consecutive lines shall stream back-to-back with no idle cycle; mode is re-sampled at each cnt==0 acceptance.
REQ-025 dwt_clr=1 shall discard the partial line and any pending output, return to S_EVEN with cnt=0, and deassert out_valid next cycle; it takes priority over a simultaneous input transfer.

Reset
REQ-026 On sys_rst=0 the block shall asynchronously enter S_EVEN with cnt=0.
REQ-027 During reset: out_valid=0, out_last=0, line_done=0, low_o=0, high_o=0, all history registers 0.
REQ-028 Reset asserted mid-line shall abandon that line; the first sample after release is x[0] of a new line.

Configuration
REQ-029 With DWT_HAAR_EN defined, Haar mode shall be compiled in and selected by mode.
REQ-030 Without DWT_HAAR_EN, the mode port shall remain present but be ignored, and the block shall always perform 5/3 lifting.

Structure
REQ-031 A shared package dwt_pkg shall hold:
- the mode encodings (MODE_LEGALL53, MODE_HAAR);
- the state enum;
- the width function coef_w(DATA_W) = DATA_W+1.
REQ-032 One sub-module, dwt_lift_step, shall hold the combinational predict/update datapath; all registers and the FSM stay in dwt_lift53_line.

Verification
REQ-033 5/3 ramp: LINE_LEN=8, x=10,20,...,80, out_ready=1 → s=10,30,50,73; d=0,0,0,10; out_last on the 4th pair; line_done one cycle later.
REQ-034 Haar (DWT_HAAR_EN defined, mode=1): same input → s=15,35,55,75; d=10,10,10,10.
REQ-035 Extremes: LINE_LEN=4, x=-128,127,-128,127 → d=255,255; s=0,0; no overflow.
REQ-036 Backpressure: constant 100, out_ready held low for 5 cycles mid-line → outputs stable, in_ready=0 while stalled, no pair lost or duplicated; all s=100, d=0.
REQ-037 Abort and reset: dwt_clr after 3 samples, then a full line → only that line's 4 pairs appear. Repeat with sys_rst pulsed asynchronously between clock edges → the same result.
